// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: PC sequencing, same-cycle word capture into a small
// decode FIFO, branch redirect with flush, and bad-PC fault detection.
module instruction_fetch_unit #(
  parameter logic [63:0] RESET_PC   = 64'd0,
  parameter int unsigned MEM_BYTES  = 16,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] Inst_Address,
  input  logic [31:0] Instruction,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [63:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        fault,
  output logic [63:0] fault_pc
);

  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam logic [63:0] LAST_PC = 64'(MEM_BYTES) - 64'd4;

  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_FAULT = 1'b1
  } state_t;

  // Unsigned 64-bit range test, optionally also demanding word alignment.
  function automatic logic pc_legal(input logic [63:0] p, input logic check_align);
    logic ok;
    ok = (p <= LAST_PC);
    if (check_align) begin
      ok = ok & (p[1:0] == 2'd0);
    end else begin
      ok = ok;
    end
    return ok;
  endfunction

  state_t             state_r;
  state_t             state_next_s;
  logic [63:0]        pc_r;
  logic [63:0]        pc_next_s;
  logic [63:0]        fault_pc_r;
  logic [63:0]        fault_pc_next_s;
  logic               fault_r;
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic [63:0]        pc_mem_r   [FIFO_DEPTH];
  logic [31:0]        word_mem_r [FIFO_DEPTH];
  logic               pop_s;
  logic               push_s;
  logic               flush_s;
  logic               not_empty_s;

  assign not_empty_s  = (count_r != CNT_W'(0));
  assign pop_s        = not_empty_s & inst_ready;
  assign Inst_Address = pc_r;
  assign inst_valid   = not_empty_s;
  assign inst_out     = not_empty_s ? word_mem_r[rd_ptr_r] : 32'd0;
  assign inst_pc      = not_empty_s ? pc_mem_r[rd_ptr_r]   : 64'd0;
  assign fault        = fault_r;
  assign fault_pc     = fault_pc_r;

  // Next-state, next-PC and FIFO write/flush decisions; redirect outranks everything.
  always_comb begin
    state_next_s    = state_r;
    pc_next_s       = pc_r;
    fault_pc_next_s = fault_pc_r;
    push_s          = 1'b0;
    flush_s         = 1'b0;
    if (redirect_valid) begin
      flush_s   = 1'b1;
      pc_next_s = redirect_pc;
      if (pc_legal(redirect_pc, 1'b1)) begin
        state_next_s = ST_FETCH;
      end else begin
        state_next_s    = ST_FAULT;
        fault_pc_next_s = redirect_pc;
      end
    end else begin
      case (state_r)
        ST_FETCH: begin
          if (pc_legal(pc_r, 1'b0)) begin
            // Full FIFO still accepts a word when the head leaves this cycle.
            if ((count_r < CNT_W'(FIFO_DEPTH)) || pop_s) begin
              push_s    = 1'b1;
              pc_next_s = pc_r + 64'd4;
            end else begin
              push_s = 1'b0;
            end
          end else begin
            state_next_s    = ST_FAULT;
            fault_pc_next_s = pc_r;
          end
        end
        ST_FAULT: begin
          push_s = 1'b0;
        end
        default: begin
          state_next_s = ST_FETCH;
        end
      endcase
    end
  end

  // Control registers: state, PC, fault status.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_FETCH;
      pc_r       <= RESET_PC;
      fault_pc_r <= 64'd0;
      fault_r    <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      pc_r       <= pc_next_s;
      fault_pc_r <= fault_pc_next_s;
      fault_r    <= (state_next_s == ST_FAULT);
    end
  end

  // FIFO pointers and occupancy; a flush empties the buffer regardless of pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else if (flush_s) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage: each entry pairs the fetch PC with the word seen at that address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        pc_mem_r[i]   <= 64'd0;
        word_mem_r[i] <= 32'd0;
      end
    end else if (push_s) begin
      pc_mem_r[wr_ptr_r]   <= pc_r;
      word_mem_r[wr_ptr_r] <= Instruction;
    end else begin
      pc_mem_r[wr_ptr_r]   <= pc_mem_r[wr_ptr_r];
      word_mem_r[wr_ptr_r] <= word_mem_r[wr_ptr_r];
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a 16-byte instruction image.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        reset;
  logic [63:0] inst_address;
  logic [31:0] instruction;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [63:0] inst_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        fault;
  logic [63:0] fault_pc;

  int n_cmp;
  int n_err;

  instruction_fetch_unit #(
    .RESET_PC  (64'd0),
    .MEM_BYTES (16),
    .FIFO_DEPTH(2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .Inst_Address  (inst_address),
    .Instruction   (instruction),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_out      (inst_out),
    .inst_pc       (inst_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .fault         (fault),
    .fault_pc      (fault_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory image, read combinationally.
  always_comb begin
    instruction = 32'h0000_0013;
    if (inst_address < 64'd16) begin
      case (inst_address[3:2])
        2'd0:    instruction = 32'h0285_3483;
        2'd1:    instruction = 32'h009A_84B3;
        2'd2:    instruction = 32'h0014_8493;
        default: instruction = 32'h0295_3423;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic head(input string tag, input logic [63:0] pc, input logic [31:0] word);
    chk({tag, "_valid"}, {63'd0, inst_valid}, 64'd1);
    chk({tag, "_pc"}, inst_pc, pc);
    chk({tag, "_word"}, {32'd0, inst_out}, {32'd0, word});
  endtask

  // Reset with inst_ready low and wait until the FIFO holds pc 0 and 4.
  task automatic fill_after_reset();
    @(negedge clk);
    reset = 1'b0;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  logic [63:0] exp_pc [4];
  logic [31:0] exp_w  [4];

  initial begin
    n_cmp = 0;
    n_err = 0;
    exp_pc[0] = 64'd0;  exp_w[0] = 32'h0285_3483;
    exp_pc[1] = 64'd4;  exp_w[1] = 32'h009A_84B3;
    exp_pc[2] = 64'd8;  exp_w[2] = 32'h0014_8493;
    exp_pc[3] = 64'd12; exp_w[3] = 32'h0295_3423;

    reset = 1'b0;
    inst_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 64'd0;
    #1;
    chk("rst_valid", {63'd0, inst_valid}, 64'd0);
    chk("rst_out", {32'd0, inst_out}, 64'd0);
    chk("rst_pc", inst_pc, 64'd0);
    chk("rst_fault", {63'd0, fault}, 64'd0);
    chk("rst_fault_pc", fault_pc, 64'd0);
    chk("rst_addr", inst_address, 64'd0);

    // Sequential run with inst_ready held high.
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      head("seq", exp_pc[i], exp_w[i]);
    end
    @(negedge clk);
    chk("seq_fault", {63'd0, fault}, 64'd1);
    chk("seq_fault_pc", fault_pc, 64'd16);
    chk("seq_drained", {63'd0, inst_valid}, 64'd0);

    // Backpressure: FIFO saturates at two entries, PC parks at 8.
    @(negedge clk);
    reset = 1'b0;
    inst_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("bp_addr", inst_address, 64'd8);
    head("bp0", 64'd0, exp_w[0]);
    inst_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      head("bp", exp_pc[i], exp_w[i]);
    end
    @(negedge clk);
    chk("bp_empty", {63'd0, inst_valid}, 64'd0);

    // Redirect flush with FIFO holding pc 0,4 and no pop.
    fill_after_reset();
    head("fl_pre", 64'd0, exp_w[0]);
    redirect_valid = 1'b1;
    redirect_pc = 64'd8;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("fl_n1_valid", {63'd0, inst_valid}, 64'd0);
    @(negedge clk);
    head("fl_tgt", 64'd8, 32'h0014_8493);
    inst_ready = 1'b1;
    @(negedge clk);
    head("fl_next", 64'd12, 32'h0295_3423);

    // Misaligned target faults; a good redirect recovers; out-of-range faults again.
    inst_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 64'd6;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("bad6_fault", {63'd0, fault}, 64'd1);
    chk("bad6_fault_pc", fault_pc, 64'd6);
    chk("bad6_valid", {63'd0, inst_valid}, 64'd0);
    @(negedge clk);
    chk("bad6_valid2", {63'd0, inst_valid}, 64'd0);
    redirect_valid = 1'b1;
    redirect_pc = 64'd4;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("rec_fault", {63'd0, fault}, 64'd0);
    @(negedge clk);
    head("rec", 64'd4, 32'h009A_84B3);
    redirect_valid = 1'b1;
    redirect_pc = 64'd16;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("bad16_fault", {63'd0, fault}, 64'd1);
    chk("bad16_fault_pc", fault_pc, 64'd16);
    chk("bad16_valid", {63'd0, inst_valid}, 64'd0);

    // Redirect coincident with a pop: pc 0 consumed, pc 4 flushed.
    fill_after_reset();
    head("cp_pre", 64'd0, exp_w[0]);
    inst_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 64'd12;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("cp_n1_valid", {63'd0, inst_valid}, 64'd0);
    @(negedge clk);
    head("cp_tgt", 64'd12, 32'h0295_3423);

    // Asynchronous reset between edges with a full FIFO.
    fill_after_reset();
    head("ar_pre", 64'd0, exp_w[0]);
    chk("ar_pre_fault", {63'd0, fault}, 64'd0);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_valid", {63'd0, inst_valid}, 64'd0);
    chk("ar_out", {32'd0, inst_out}, 64'd0);
    chk("ar_pc", inst_pc, 64'd0);
    chk("ar_addr", inst_address, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    inst_ready = 1'b1;
    @(negedge clk);
    head("ar_r0", 64'd0, exp_w[0]);
    @(negedge clk);
    head("ar_r1", 64'd4, exp_w[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation time limit reached");
  end

endmodule
